// File: rtl/inst_seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, NOP word
// and the default reset PC, used by the RTL, the tracer and the testbench.
package inst_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_e;

    // Plain-vector aliases so the FSM register stays a legacy-friendly logic [2:0]
    localparam logic [2:0] S_FETCH = ST_FETCH;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_EXEC  = ST_EXEC;
    localparam logic [2:0] S_WB    = ST_WB;
    localparam logic [2:0] S_HALT  = ST_HALT;
    localparam logic [2:0] S_FAULT = ST_FAULT;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Saturating cycle counter for the fetch-response timeout; hit flags the cycle
// in which the count of enabled cycles (including the current one) reaches limit.
module seq_timeout_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt < limit)) begin
            cnt <= cnt + W'(1);
        end
    end

    // cnt holds the number of completed cycles, so the current cycle is cnt+1
    assign hit = (limit == '0) || (cnt >= (limit - W'(1)));

endmodule

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, wait for memory response, execute,
// write back, with a response timeout and terminal HALT/FAULT states.
module inst_seq_ctrl #(
    parameter logic [31:0] RESET_PC     = inst_seq_ctrl_pkg::DEFAULT_RESET_PC,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        exu_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic        reg_wen,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    import inst_seq_ctrl_pkg::*;

    localparam logic [31:0] TO_LIMIT = 32'(RESP_TIMEOUT);

    logic        br_taken_q;
    logic [31:0] br_target_q;
    logic        halt_q;
    logic        to_hit;
    logic        misalign;

    seq_timeout_cnt #(
        .W(32)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_FETCH),
        .en    (state == S_WAIT),
        .limit (TO_LIMIT),
        .hit   (to_hit)
    );

    // A taken branch to a non-word-aligned target cannot be fetched
    assign misalign = br_taken_q && (br_target_q[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            inst        <= NOP_INST;
            instret     <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            halt_q      <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response in the timeout cycle still wins over FAULT
                    if (imem_resp_valid) begin
                        inst  <= imem_resp_data;
                        state <= S_EXEC;
                    end else if (to_hit) begin
                        state <= S_FAULT;
                    end
                end
                S_EXEC: begin
                    if (exu_done) begin
                        br_taken_q  <= branch_taken;
                        br_target_q <= branch_target;
                        halt_q      <= halt_req;
                        state       <= S_WB;
                    end
                end
                S_WB: begin
                    instret <= instret + 32'd1;
                    if (misalign) begin
                        state <= S_FAULT;
                    end else begin
                        pc    <= br_taken_q ? br_target_q : (pc + 32'd4);
                        state <= halt_q ? S_HALT : S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
        end
    end

    assign imem_req_valid = (state == S_FETCH);
    assign imem_addr      = pc;
    assign reg_wen        = (state == S_WB);
    assign halted         = (state == S_HALT);
    assign fault          = (state == S_FAULT);

endmodule
